vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_axis_cnt.sv | 76 +++++++
 rtl/vga_timing_gen.sv | 118 +++++++++++
 tb/tb_vga_timing_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared raster-mode constants and helpers for the VGA timing chain.
//   CNT_W_DEF      default hcount/vcount width
//   POL_LOW/HIGH   sync polarity encodings (active level)
//   MODE_*         porch/sync sets for the supported raster modes
package vga_pkg;

  localparam int unsigned CNT_W_DEF = 11;

  localparam bit POL_LOW  = 1'b0;
  localparam bit POL_HIGH = 1'b1;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } vga_mode_t;

  // 1024x768 at 75 MHz pixel clock
  localparam vga_mode_t MODE_XGA_75M = '{
    h_active: 1024, h_fp: 24, h_sync: 136, h_bp: 144,
    v_active: 768,  v_fp: 3,  v_sync: 6,   v_bp: 29
  };

  // 800x600 at 40 MHz pixel clock
  localparam vga_mode_t MODE_SVGA_40M = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
  };

  // Output level of a sync line given whether it is in its sync window
  function automatic logic sync_lvl(input logic active, input bit pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping counter with registered blank and sync levels.
//   pclk, rst     clock, async active-low reset
//   adv           advance by one position this cycle
//   cnt_o         current position (registered)
//   blnk_o        high when position >= ACTIVE (registered)
//   sync_o        POL while inside the sync window, ~POL otherwise (registered)
//   blnk_c_o      blank level of the next position (combinational)
//   wrap_c_o      high in the cycle the counter wraps to 0 (combinational)
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned ACTIVE = MODE_XGA_75M.h_active,
  parameter int unsigned FP     = MODE_XGA_75M.h_fp,
  parameter int unsigned SYNC   = MODE_XGA_75M.h_sync,
  parameter int unsigned BP     = MODE_XGA_75M.h_bp,
  parameter bit          POL    = POL_LOW
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt_o,
  output logic             blnk_o,
  output logic             sync_o,
  output logic             blnk_c_o,
  output logic             wrap_c_o
);

  localparam int unsigned TOTAL    = ACTIVE + FP + SYNC + BP;
  localparam int unsigned SYNC_BEG = ACTIVE + FP;
  localparam int unsigned SYNC_END = SYNC_BEG + SYNC;  // exclusive

  if (64'(TOTAL) > (64'd1 << CNT_W)) begin : g_total_chk
    $error("vga_axis_cnt: total %0d does not fit in %0d bits", TOTAL, CNT_W);
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blnk_q, blnk_d;
  logic             sync_q, sync_d;
  logic             wrap_c;

  // Next position; blank/sync are decoded from it so they line up with cnt
  always_comb begin
    wrap_c = 1'b0;
    cnt_d  = cnt_q;
    if (adv) begin
      if (cnt_q == CNT_W'(TOTAL - 1)) begin
        wrap_c = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    blnk_d = (32'(cnt_d) >= ACTIVE);
    sync_d = sync_lvl((32'(cnt_d) >= SYNC_BEG) && (32'(cnt_d) < SYNC_END), POL);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      blnk_q <= 1'b0;
      sync_q <= sync_lvl(1'b0, POL);
    end else begin
      cnt_q  <= cnt_d;
      blnk_q <= blnk_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign blnk_o   = blnk_q;
  assign sync_o   = sync_q;
  assign blnk_c_o = blnk_d;
  assign wrap_c_o = wrap_c;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator (head of the pclk pixel pipeline).
//   pclk, rst      pixel clock, async active-low reset
//   en             advance enable; low freezes the raster and masks pulses
//   hcount/vcount  current pixel column / line
//   hsync/vsync    sync at H_POL/V_POL level inside the sync window
//   hblnk/vblnk    blanking flags; de = active video
//   line_start     one-cycle pulse when hcount wraps to 0
//   frame_start    one-cycle pulse when the raster wraps to (0,0)
//   frame_cnt      completed-frame count, wraps modulo 2^FRAME_W
// All outputs are registered from the same next-state values, so every
// flag in a cycle describes the (hcount, vcount) presented in that cycle.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned H_ACTIVE = MODE_XGA_75M.h_active,
  parameter int unsigned H_FP     = MODE_XGA_75M.h_fp,
  parameter int unsigned H_SYNC   = MODE_XGA_75M.h_sync,
  parameter int unsigned H_BP     = MODE_XGA_75M.h_bp,
  parameter int unsigned V_ACTIVE = MODE_XGA_75M.v_active,
  parameter int unsigned V_FP     = MODE_XGA_75M.v_fp,
  parameter int unsigned V_SYNC   = MODE_XGA_75M.v_sync,
  parameter int unsigned V_BP     = MODE_XGA_75M.v_bp,
  parameter bit          H_POL    = POL_LOW,
  parameter bit          V_POL    = POL_LOW,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               en,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  logic h_blnk_c, v_blnk_c;
  logic h_wrap_c, v_wrap_c;

  logic               de_q, de_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  vga_axis_cnt #(
    .CNT_W (CNT_W),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .POL   (H_POL)
  ) u_h (
    .pclk    (pclk),
    .rst     (rst),
    .adv     (en),
    .cnt_o   (hcount),
    .blnk_o  (hblnk),
    .sync_o  (hsync),
    .blnk_c_o(h_blnk_c),
    .wrap_c_o(h_wrap_c)
  );

  // Vertical advances only on the horizontal wrap, so vsync moves at hcount = 0
  vga_axis_cnt #(
    .CNT_W (CNT_W),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .POL   (V_POL)
  ) u_v (
    .pclk    (pclk),
    .rst     (rst),
    .adv     (h_wrap_c),
    .cnt_o   (vcount),
    .blnk_o  (vblnk),
    .sync_o  (vsync),
    .blnk_c_o(v_blnk_c),
    .wrap_c_o(v_wrap_c)
  );

  // Wrap strobes already include en, so pulses are masked while frozen
  always_comb begin
    line_start_d  = h_wrap_c;
    frame_start_d = h_wrap_c & v_wrap_c;
    frame_cnt_d   = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + FRAME_W'(1);
    end
    de_d = ~(h_blnk_c | v_blnk_c);
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (small active-low mode with a
// 2-bit frame counter, small active-high mode, default XGA mode) share pclk,
// rst and en. Expected outputs come from the raster position implied by the
// number of enabled cycles since reset.
module tb_vga_timing_gen;

  // Small mode S: 25 x 16 raster, active-low syncs, FRAME_W = 2
  localparam int unsigned S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 4;
  localparam int unsigned S_VA = 10, S_VF = 1, S_VS = 2, S_VB = 3;
  // Small mode P: 24 x 11 raster, active-high syncs, FRAME_W = 4
  localparam int unsigned P_HA = 12, P_HF = 3, P_HS = 4, P_HB = 5;
  localparam int unsigned P_VA = 6,  P_VF = 1, P_VS = 2, P_VB = 2;
  // Default mode D: 1024x768 XGA timings
  localparam int unsigned D_HA = 1024, D_HF = 24, D_HS = 136, D_HB = 144;
  localparam int unsigned D_VA = 768,  D_VF = 3,  D_VS = 6,   D_VB = 29;

  typedef struct {
    int unsigned hc, vc, hs, vs, hb, vb, de, ls, fs, fc;
  } obs_t;

  logic pclk = 1'b0;
  logic rst;
  logic en;

  logic [5:0]  hc_s, vc_s;
  logic        hs_s, vs_s, hb_s, vb_s, de_s, ls_s, fs_s;
  logic [1:0]  fc_s;
  logic [4:0]  hc_p, vc_p;
  logic        hs_p, vs_p, hb_p, vb_p, de_p, ls_p, fs_p;
  logic [3:0]  fc_p;
  logic [10:0] hc_d, vc_d;
  logic        hs_d, vs_d, hb_d, vb_d, de_d, ls_d, fs_d;
  logic [15:0] fc_d;

  longint unsigned n;      // enabled cycles since reset release
  bit              le;     // en was high (and not in reset) at the last edge
  int unsigned     n_assert;
  int unsigned     n_fail;

  always #5 pclk = ~pclk;

  vga_timing_gen #(
    .CNT_W(6), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .H_POL(1'b0), .V_POL(1'b0), .FRAME_W(2)
  ) dut_s (
    .pclk(pclk), .rst(rst), .en(en), .hcount(hc_s), .vcount(vc_s),
    .hsync(hs_s), .vsync(vs_s), .hblnk(hb_s), .vblnk(vb_s), .de(de_s),
    .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s)
  );

  vga_timing_gen #(
    .CNT_W(5), .H_ACTIVE(P_HA), .H_FP(P_HF), .H_SYNC(P_HS), .H_BP(P_HB),
    .V_ACTIVE(P_VA), .V_FP(P_VF), .V_SYNC(P_VS), .V_BP(P_VB),
    .H_POL(1'b1), .V_POL(1'b1), .FRAME_W(4)
  ) dut_p (
    .pclk(pclk), .rst(rst), .en(en), .hcount(hc_p), .vcount(vc_p),
    .hsync(hs_p), .vsync(vs_p), .hblnk(hb_p), .vblnk(vb_p), .de(de_p),
    .line_start(ls_p), .frame_start(fs_p), .frame_cnt(fc_p)
  );

  vga_timing_gen dut_d (
    .pclk(pclk), .rst(rst), .en(en), .hcount(hc_d), .vcount(vc_d),
    .hsync(hs_d), .vsync(vs_d), .hblnk(hb_d), .vblnk(vb_d), .de(de_d),
    .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fc_d)
  );

  // Raster position after k enabled cycles is simply k mod (H_TOTAL*V_TOTAL)
  function automatic obs_t model(input longint unsigned k, input bit last_en,
                                 input int unsigned ha, hf, hsw, hbp,
                                 input int unsigned va, vf, vsw, vbp,
                                 input bit hp, vp, input int unsigned fw);
    obs_t r;
    longint unsigned ht, vt, ft, p, h, v, hs0, vs0;
    ht  = 64'(ha) + 64'(hf) + 64'(hsw) + 64'(hbp);
    vt  = 64'(va) + 64'(vf) + 64'(vsw) + 64'(vbp);
    ft  = ht * vt;
    p   = k % ft;
    h   = p % ht;
    v   = p / ht;
    hs0 = 64'(ha) + 64'(hf);
    vs0 = 64'(va) + 64'(vf);
    r.hc = 32'(h);
    r.vc = 32'(v);
    r.hs = ((h >= hs0) && (h < hs0 + 64'(hsw))) ? 32'(hp) : 32'(!hp);
    r.vs = ((v >= vs0) && (v < vs0 + 64'(vsw))) ? 32'(vp) : 32'(!vp);
    r.hb = (h >= 64'(ha)) ? 32'd1 : 32'd0;
    r.vb = (v >= 64'(va)) ? 32'd1 : 32'd0;
    r.de = (r.hb == 0 && r.vb == 0) ? 32'd1 : 32'd0;
    r.ls = (last_en && k > 0 && h == 0) ? 32'd1 : 32'd0;
    r.fs = (last_en && k > 0 && p == 0) ? 32'd1 : 32'd0;
    r.fc = 32'((k / ft) % (64'd1 << fw));
    return r;
  endfunction

  task automatic cmp(input string tag, input int unsigned got, input int unsigned exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic cmp_obs(input string tag, input obs_t o, input obs_t e);
    cmp({tag, ".hcount"},      o.hc, e.hc);
    cmp({tag, ".vcount"},      o.vc, e.vc);
    cmp({tag, ".hsync"},       o.hs, e.hs);
    cmp({tag, ".vsync"},       o.vs, e.vs);
    cmp({tag, ".hblnk"},       o.hb, e.hb);
    cmp({tag, ".vblnk"},       o.vb, e.vb);
    cmp({tag, ".de"},          o.de, e.de);
    cmp({tag, ".line_start"},  o.ls, e.ls);
    cmp({tag, ".frame_start"}, o.fs, e.fs);
    cmp({tag, ".frame_cnt"},   o.fc, e.fc);
  endtask

  task automatic check_all();
    obs_t o;
    o = '{32'(hc_s), 32'(vc_s), 32'(hs_s), 32'(vs_s), 32'(hb_s), 32'(vb_s),
          32'(de_s), 32'(ls_s), 32'(fs_s), 32'(fc_s)};
    cmp_obs("S", o, model(n, le, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB,
                          1'b0, 1'b0, 2));
    o = '{32'(hc_p), 32'(vc_p), 32'(hs_p), 32'(vs_p), 32'(hb_p), 32'(vb_p),
          32'(de_p), 32'(ls_p), 32'(fs_p), 32'(fc_p)};
    cmp_obs("P", o, model(n, le, P_HA, P_HF, P_HS, P_HB, P_VA, P_VF, P_VS, P_VB,
                          1'b1, 1'b1, 4));
    o = '{32'(hc_d), 32'(vc_d), 32'(hs_d), 32'(vs_d), 32'(hb_d), 32'(vb_d),
          32'(de_d), 32'(ls_d), 32'(fs_d), 32'(fc_d)};
    cmp_obs("D", o, model(n, le, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB,
                          1'b0, 1'b0, 16));
  endtask

  // Drive en between edges, take one edge, then sample 1 time unit later
  task automatic step(input bit e);
    en = e;
    @(posedge pclk);
    le = e && (rst === 1'b1);
    if (le) n++;
    #1;
    check_all();
  endtask

  initial begin
    n        = 0;
    le       = 1'b0;
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b0;
    en       = 1'b0;

    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    check_all();
    #2 rst = 1'b1;

    // Run the default instance to hcount = 500, then reset mid-line
    repeat (500) step(1'b1);
    cmp("D.pre_reset_hcount", 32'(hc_d), 32'd500);
    #2 rst = 1'b0;
    #1;
    n  = 0;
    le = 1'b0;
    check_all();
    en = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    check_all();
    rst = 1'b1;

    // First enabled edge after release presents (1,0), no frame_start
    step(1'b1);
    cmp("S.first_hcount", 32'(hc_s), 32'd1);
    cmp("D.first_frame_start", 32'(fs_d), 32'd0);

    // Free run: several small frames, frame_cnt of S wraps through 3 -> 0
    repeat (3000) step(1'b1);

    // Freeze at the last column of S for 10 cycles, then release
    while ((n % 25) != 24) step(1'b1);
    repeat (10) step(1'b0);
    step(1'b1);
    cmp("S.reenable_hcount", 32'(hc_s), 32'd0);
    cmp("S.reenable_line_start", 32'(ls_s), 32'd1);

    // Random enable pattern
    repeat (20000) step($urandom_range(0, 3) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
